// File: rtl/multiplier_arbiter_pkg.sv
// Shared constants and types for the multiplier arbiter slice.
package mult_arb_pkg;

  localparam int MULT_WIDTH       = 64;
  localparam int DEF_NREQ         = 4;
  localparam int DEF_MULT_LATENCY = 6;

  // Index field sized for the largest legal requester count (8).
  localparam int TAG_IDX_W = 3;

  // One tag per multiplier pipeline slot: occupied flag plus issuing requester.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/multiplier_arbiter_if.sv
// Requester and external-multiplier bus of the multiplier arbiter.
// slave: the arbiter side; master: requesters plus the external multiplier.
interface multiplier_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [MULT_WIDTH*NREQ-1:0] req_a;
  logic [MULT_WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]            res_valid;
  logic [MULT_WIDTH-1:0]      res_p;
  logic                       mult_ce;
  logic [MULT_WIDTH-1:0]      mult_a;
  logic [MULT_WIDTH-1:0]      mult_b;
  logic [MULT_WIDTH-1:0]      mult_p;

  modport slave (
    input  req_valid, req_a, req_b, mult_p,
    output req_ready, res_valid, res_p, mult_ce, mult_a, mult_b
  );

  modport master (
    output req_valid, req_a, req_b, mult_p,
    input  req_ready, res_valid, res_p, mult_ce, mult_a, mult_b
  );

endinterface

// File: rtl/multiplier_arbiter_rr_arbiter.sv
// Round-robin grant over NREQ requesters with a registered priority pointer.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_vld
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;

  // First requesting index at or after the pointer, wrapping; nothing during reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!reset && !grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer moves just past the granted requester; holds when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one external pipelined 64-bit multiplier among NREQ requesters.
// Optional macro MULT_ARB_STATS_EN adds a saturating 32-bit issue_count output.
module multiplier_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ         = DEF_NREQ,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  multiplier_arbiter_if.slave  bus
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]          issue_count
`endif
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant_vld;

  logic [MULT_WIDTH-1:0] a_sel, b_sel;
  logic [MULT_WIDTH-1:0] mult_a_q, mult_a_d;
  logic [MULT_WIDTH-1:0] mult_b_q, mult_b_d;
  logic [NREQ-1:0]       res_valid_q, res_valid_d;
  logic [MULT_WIDTH-1:0] res_p_q, res_p_d;
  tag_t                  tag_q [MULT_LATENCY+1];
  tag_t                  tag_d [MULT_LATENCY+1];

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Operand mux from the one-hot grant.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = bus.req_a[i*MULT_WIDTH +: MULT_WIDTH];
        b_sel = bus.req_b[i*MULT_WIDTH +: MULT_WIDTH];
      end
    end
  end

  // Operand capture, tag shift and result formation.
  // Stage 0 is written alongside mult_a/mult_b, so the last stage lines up with mult_p.
  always_comb begin
    mult_a_d = grant_vld ? a_sel : mult_a_q;
    mult_b_d = grant_vld ? b_sel : mult_b_q;
    tag_d[0] = '{valid: grant_vld, idx: TAG_IDX_W'(grant_idx)};
    for (int unsigned k = 1; k <= MULT_LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    res_valid_d = '0;
    res_p_d     = res_p_q;
    if (tag_q[MULT_LATENCY].valid) begin
      res_valid_d = NREQ'(1) << tag_q[MULT_LATENCY].idx;
      res_p_d     = bus.mult_p;
    end
  end

  // Datapath and tag registers; reset flushes every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      res_valid_q <= '0;
      res_p_q     <= '0;
      for (int unsigned k = 0; k <= MULT_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      res_valid_q <= res_valid_d;
      res_p_q     <= res_p_d;
      for (int unsigned k = 0; k <= MULT_LATENCY; k++) tag_q[k] <= tag_d[k];
    end
  end

  assign bus.req_ready = grant;
  assign bus.mult_ce   = ~reset;
  assign bus.mult_a    = mult_a_q;
  assign bus.mult_b    = mult_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_p     = res_p_q;

`ifdef MULT_ARB_STATS_EN
  logic [31:0] issue_count_q, issue_count_d;

  // Transfer counter, saturating at all-ones.
  always_comb begin
    issue_count_d = issue_count_q;
    if (grant_vld && (issue_count_q != '1)) issue_count_d = issue_count_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) issue_count_q <= '0;
    else       issue_count_q <= issue_count_d;
  end

  assign issue_count = issue_count_q;
`endif

endmodule
